// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   localparam logic        CHIP_ENABLE   = 1'b1;
   localparam logic        CHIP_DISABLE  = 1'b0;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   // An access is complete while its own ack is on the bus, or while its result waits in HOLD.
   function automatic logic owner_done(input state_e st, input owner_e own,
                                       input owner_e who, input logic ack);
      return ((st == ST_BUSY) && (own == who) && ack) ||
             ((st == ST_HOLD) && (own == who));
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_mux.sv
// Combinational two-to-one request selector; the data port always wins
// over instruction fetch.
module mem_bus_arbiter_req_mux
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = DATA_W / 8
) (
   input  logic              i_ce_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic              d_ce_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [SEL_W-1:0]  d_sel_i,
   input  logic [DATA_W-1:0] d_data_i,
   output logic              req_valid_o,
   output logic              req_owner_o,
   output logic              req_we_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [SEL_W-1:0]  req_sel_o,
   output logic [DATA_W-1:0] req_data_o
);

   // Fixed-priority pick; fetches are full-word reads with no store data.
   always_comb begin
      req_valid_o = CHIP_DISABLE;
      req_owner_o = OWNER_I;
      req_we_o    = WRITE_DISABLE;
      req_addr_o  = {ADDR_W{1'b0}};
      req_sel_o   = {SEL_W{1'b0}};
      req_data_o  = {DATA_W{1'b0}};
      if (d_ce_i == CHIP_ENABLE) begin
         req_valid_o = CHIP_ENABLE;
         req_owner_o = OWNER_D;
         req_we_o    = d_we_i;
         req_addr_o  = d_addr_i;
         req_sel_o   = d_sel_i;
         req_data_o  = d_data_i;
      end else if (i_ce_i == CHIP_ENABLE) begin
         req_valid_o = CHIP_ENABLE;
         req_owner_o = OWNER_I;
         req_we_o    = WRITE_DISABLE;
         req_addr_o  = i_addr_i;
         req_sel_o   = {SEL_W{1'b1}};
         req_data_o  = {DATA_W{1'b0}};
      end else begin
         req_valid_o = CHIP_DISABLE;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone master port between the I-fetch and D load/store
// requesters, stalling each until its registered bus cycle is acked.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ce_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic [DATA_W-1:0] i_data_o,
   output logic              i_stallreq_o,
   input  logic              d_ce_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [SEL_W-1:0]  d_sel_i,
   input  logic [DATA_W-1:0] d_data_i,
   output logic [DATA_W-1:0] d_data_o,
   output logic              d_stallreq_o,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i
);

   state_e            state_q;
   owner_e            owner_q;
   logic              flush_seen_q;
   logic [DATA_W-1:0] i_buf_q;
   logic [DATA_W-1:0] d_buf_q;
   logic              wb_cyc_q;
   logic              wb_stb_q;
   logic              wb_we_q;
   logic [ADDR_W-1:0] wb_adr_q;
   logic [SEL_W-1:0]  wb_sel_q;
   logic [DATA_W-1:0] wb_dat_q;

   logic              req_valid;
   logic              req_owner;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [SEL_W-1:0]  req_sel;
   logic [DATA_W-1:0] req_data;
   logic              i_done;
   logic              d_done;
   logic              i_bypass;
   logic              d_bypass;

   mem_bus_arbiter_req_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_req_mux (
      .i_ce_i      (i_ce_i),
      .i_addr_i    (i_addr_i),
      .d_ce_i      (d_ce_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_sel_i     (d_sel_i),
      .d_data_i    (d_data_i),
      .req_valid_o (req_valid),
      .req_owner_o (req_owner),
      .req_we_o    (req_we),
      .req_addr_o  (req_addr),
      .req_sel_o   (req_sel),
      .req_data_o  (req_data)
   );

   assign i_done       = owner_done(state_q, owner_q, OWNER_I, wb_ack_i);
   assign d_done       = owner_done(state_q, owner_q, OWNER_D, wb_ack_i);
   assign i_stallreq_o = i_ce_i & ~i_done;
   assign d_stallreq_o = d_ce_i & ~d_done;

   // Ack-cycle data goes straight through so a zero-wait slave costs no extra cycle.
   assign i_bypass = (state_q == ST_BUSY) && (owner_q == OWNER_I) && wb_ack_i;
   assign d_bypass = (state_q == ST_BUSY) && (owner_q == OWNER_D) && wb_ack_i;
   assign i_data_o = i_bypass ? wb_dat_i : i_buf_q;
   assign d_data_o = d_bypass ? wb_dat_i : d_buf_q;

   assign wb_cyc_o = wb_cyc_q;
   assign wb_stb_o = wb_stb_q;
   assign wb_we_o  = wb_we_q;
   assign wb_adr_o = wb_adr_q;
   assign wb_sel_o = wb_sel_q;
   assign wb_dat_o = wb_dat_q;

   // Bus-cycle FSM; every wb_* output is driven straight from a register here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_I;
         flush_seen_q <= 1'b0;
         i_buf_q      <= {DATA_W{1'b0}};
         d_buf_q      <= {DATA_W{1'b0}};
         wb_cyc_q     <= 1'b0;
         wb_stb_q     <= 1'b0;
         wb_we_q      <= 1'b0;
         wb_adr_q     <= {ADDR_W{1'b0}};
         wb_sel_q     <= {SEL_W{1'b0}};
         wb_dat_q     <= {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && !flush_i) begin
                  state_q  <= ST_BUSY;
                  owner_q  <= owner_e'(req_owner);
                  wb_cyc_q <= 1'b1;
                  wb_stb_q <= 1'b1;
                  wb_we_q  <= req_we;
                  wb_adr_q <= req_addr;
                  wb_sel_q <= req_sel;
                  wb_dat_q <= req_data;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (wb_ack_i) begin
                  wb_cyc_q     <= 1'b0;
                  wb_stb_q     <= 1'b0;
                  wb_we_q      <= 1'b0;
                  wb_adr_q     <= {ADDR_W{1'b0}};
                  wb_sel_q     <= {SEL_W{1'b0}};
                  wb_dat_q     <= {DATA_W{1'b0}};
                  flush_seen_q <= 1'b0;
                  // A flush seen at any point of the cycle discards its result.
                  if (flush_seen_q || flush_i) begin
                     state_q <= ST_IDLE;
                  end else if (stall_i) begin
                     state_q <= ST_HOLD;
                     if (owner_q == OWNER_D) begin
                        d_buf_q <= wb_dat_i;
                     end else begin
                        i_buf_q <= wb_dat_i;
                     end
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  flush_seen_q <= flush_seen_q | flush_i;
               end
            end
            ST_HOLD: begin
               if (!stall_i || flush_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: launch-decision vector table,
// hand-written corner sequences and a randomized run against a memory model.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_ce, d_ce, d_we, stall_i, flush_i;
   logic [AW-1:0] i_addr, d_addr;
   logic [SW-1:0] d_sel;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] i_data_o, d_data_o;
   logic          i_stallreq_o, d_stallreq_o;
   logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [AW-1:0] wb_adr_o;
   logic [SW-1:0] wb_sel_o;
   logic [DW-1:0] wb_dat_o, wb_dat_i;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_ce_i       (i_ce),
      .i_addr_i     (i_addr),
      .i_data_o     (i_data_o),
      .i_stallreq_o (i_stallreq_o),
      .d_ce_i       (d_ce),
      .d_we_i       (d_we),
      .d_addr_i     (d_addr),
      .d_sel_i      (d_sel),
      .d_data_i     (d_wdata),
      .d_data_o     (d_data_o),
      .d_stallreq_o (d_stallreq_o),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_o     (wb_dat_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Power-on memory contents, keyed by word index.
   function automatic logic [31:0] init_word(input int idx);
      if (idx == 64) return 32'h2402_0005;
      if (idx == 16) return 32'hDEAD_BEEF;
      return 32'hA000_0000 + 32'(idx) * 32'h0001_0101;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Bus slave: acks after slv_lat wait cycles, 256-word memory.
   int          slv_lat = 0;
   int          slv_cnt;
   logic [31:0] slv_mem [256];
   bit          slv_wr  [256];
   logic [7:0]  slv_idx;
   assign slv_idx  = wb_adr_o[9:2];
   assign wb_ack_i = wb_cyc_o && wb_stb_o && (slv_cnt == slv_lat);
   always_comb begin
      wb_dat_i = 32'h0;
      if (wb_ack_i) wb_dat_i = slv_wr[slv_idx] ? slv_mem[slv_idx] : init_word(int'(slv_idx));
   end
   always @(posedge clk) begin
      if (!rst) slv_cnt <= 0;
      else if (wb_cyc_o && wb_stb_o && !wb_ack_i) slv_cnt <= slv_cnt + 1;
      else slv_cnt <= 0;
      if (rst && wb_ack_i && wb_we_o) begin
         slv_mem[slv_idx] <= merge(slv_wr[slv_idx] ? slv_mem[slv_idx] : init_word(int'(slv_idx)),
                                   wb_dat_o, wb_sel_o);
         slv_wr[slv_idx]  <= 1'b1;
      end
   end

   // Reference memory: what every requester should observe, built from the issued requests.
   logic [31:0] ref_mem [256];
   bit          ref_wr  [256];
   function automatic logic [31:0] ref_read(input int idx);
      return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
   endfunction
   task automatic ref_write(input int idx, input logic [31:0] d, input logic [3:0] sel);
      ref_mem[idx] = merge(ref_read(idx), d, sel);
      ref_wr[idx]  = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   logic [68:0] stb_saved;
   bit          stb_prev = 1'b0;

   // Move to the sampling point of the current cycle and check bus stability from strobe to ack.
   task automatic half();
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) begin
         if (stb_prev) begin
            checks++;
            if ({wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== stb_saved) begin
               errors++;
               $display("FAIL wb_stable: got %h, expected %h", {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, stb_saved);
            end
         end
         stb_saved = {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};
         stb_prev  = !wb_ack_i;
      end else begin
         stb_prev = 1'b0;
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_sel = 4'h0; d_wdata = 32'h0;
   endtask

   typedef struct {
      logic        i_ce, d_ce, d_we, flush;
      logic [31:0] i_addr, d_addr;
      logic [3:0]  d_sel;
      logic [31:0] d_data;
      logic        idle_istall, idle_dstall;
      logic        cyc, we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        ack_istall, ack_dstall;
   } vec_t;

   vec_t vecs [6];

   logic        r_d, r_we, r_stl, done, stl_now;
   logic [31:0] r_addr, r_data, r_exp, got;
   logic [3:0]  r_sel;
   int          waited;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      // {i_ce,d_ce,d_we,flush, i_addr,d_addr,d_sel,d_data, idle stalls I/D, cyc,we,adr,sel,dat, ack-cycle stalls I/D}
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0204, 4'h3, 32'h1234_5678,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 4'h3, 32'h1234_5678, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_020C, 4'hF, 32'hCAFE_0000,
                  1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_020C, 4'hF, 32'hCAFE_0000, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'h0,
                  1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0204, 4'hF, 32'h0000_0001,
                  1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1};

      clear_inputs();
      rst = 1'b0;
      next(); next();
      half();
      chk("rst_cyc", wb_cyc_o, 1'b0);   chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_we", wb_we_o, 1'b0);     chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_sel", wb_sel_o, 4'h0);   chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_istall", i_stallreq_o, 1'b0); chk("rst_dstall", d_stallreq_o, 1'b0);
      chk("rst_idata", i_data_o, 32'h0);     chk("rst_ddata", d_data_o, 32'h0);
      rst = 1'b1;
      next();

      // Launch decisions from IDLE against a zero-wait slave.
      slv_lat = 0;
      for (int k = 0; k < 6; k++) begin
         i_ce = vecs[k].i_ce; d_ce = vecs[k].d_ce; d_we = vecs[k].d_we; flush_i = vecs[k].flush;
         i_addr = vecs[k].i_addr; d_addr = vecs[k].d_addr; d_sel = vecs[k].d_sel; d_wdata = vecs[k].d_data;
         half();
         chk($sformatf("vec%0d_idle_istall", k), i_stallreq_o, vecs[k].idle_istall);
         chk($sformatf("vec%0d_idle_dstall", k), d_stallreq_o, vecs[k].idle_dstall);
         next(); half();
         chk($sformatf("vec%0d_cyc", k), wb_cyc_o, vecs[k].cyc);
         chk($sformatf("vec%0d_stb", k), wb_stb_o, vecs[k].cyc);
         chk($sformatf("vec%0d_we", k), wb_we_o, vecs[k].we);
         chk($sformatf("vec%0d_adr", k), wb_adr_o, vecs[k].adr);
         chk($sformatf("vec%0d_sel", k), wb_sel_o, vecs[k].sel);
         chk($sformatf("vec%0d_dat", k), wb_dat_o, vecs[k].dat);
         chk($sformatf("vec%0d_ack_istall", k), i_stallreq_o, vecs[k].ack_istall);
         chk($sformatf("vec%0d_ack_dstall", k), d_stallreq_o, vecs[k].ack_dstall);
         if (vecs[k].d_ce && vecs[k].d_we && !vecs[k].flush)
            ref_write(int'(vecs[k].d_addr[9:2]), vecs[k].d_data, vecs[k].d_sel);
         next();
         clear_inputs();
      end

      // Single I read, slave acks one cycle after the strobe.
      slv_lat = 1; i_ce = 1'b1; i_addr = 32'h0000_0100;
      half(); chk("A_istall_c0", i_stallreq_o, 1'b1); next();
      half(); chk("A_istall_c1", i_stallreq_o, 1'b1); chk("A_stb", wb_stb_o, 1'b1);
      chk("A_we", wb_we_o, 1'b0); chk("A_sel", wb_sel_o, 4'hF); next();
      half(); chk("A_ack", wb_ack_i, 1'b1); chk("A_istall_ack", i_stallreq_o, 1'b0);
      chk("A_idata", i_data_o, 32'h2402_0005); next();
      i_ce = 1'b0;
      half(); chk("A_cyc_after", wb_cyc_o, 1'b0); next();

      // Simultaneous I and D: store byte goes first, one IDLE, then the fetch.
      slv_lat = 0;
      i_ce = 1'b1; i_addr = 32'h0000_0100;
      d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0203; d_sel = 4'b0001; d_wdata = 32'h4444_4444;
      half(); chk("B_istall_c0", i_stallreq_o, 1'b1); chk("B_dstall_c0", d_stallreq_o, 1'b1); next();
      half(); chk("B_we", wb_we_o, 1'b1); chk("B_sel", wb_sel_o, 4'b0001);
      chk("B_adr", wb_adr_o, 32'h0000_0203); chk("B_dat", wb_dat_o, 32'h4444_4444);
      chk("B_dstall_ack", d_stallreq_o, 1'b0); chk("B_istall_wait", i_stallreq_o, 1'b1);
      ref_write(128, 32'h4444_4444, 4'b0001);
      next();
      d_ce = 1'b0; d_we = 1'b0;
      half(); chk("B_idle_gap", wb_cyc_o, 1'b0); chk("B_istall_gap", i_stallreq_o, 1'b1); next();
      half(); chk("B_i_cyc", wb_cyc_o, 1'b1); chk("B_i_adr", wb_adr_o, 32'h0000_0100);
      chk("B_i_we", wb_we_o, 1'b0); chk("B_istall_ack", i_stallreq_o, 1'b0);
      chk("B_idata", i_data_o, 32'h2402_0005); next();
      clear_inputs();

      // D load completes under a global stall: result held until the stall lifts.
      slv_lat = 0; d_ce = 1'b1; d_addr = 32'h0000_0040; d_sel = 4'hF; stall_i = 1'b1;
      half(); next();
      half(); chk("C_dstall_ack", d_stallreq_o, 1'b0); chk("C_ddata_ack", d_data_o, 32'hDEAD_BEEF); next();
      half(); chk("C_dstall_hold", d_stallreq_o, 1'b0); chk("C_ddata_hold", d_data_o, 32'hDEAD_BEEF);
      chk("C_cyc_hold", wb_cyc_o, 1'b0); next();
      half(); chk("C_dstall_hold2", d_stallreq_o, 1'b0); chk("C_ddata_hold2", d_data_o, 32'hDEAD_BEEF);
      stall_i = 1'b0; next();
      half(); chk("C_dstall_idle", d_stallreq_o, 1'b1); chk("C_ddata_idle", d_data_o, 32'hDEAD_BEEF);
      d_ce = 1'b0; next();
      half(); chk("C_cyc_end", wb_cyc_o, 1'b0); next();
      clear_inputs();

      // Flush pulse mid-cycle: the bus cycle completes, the result is dropped (no HOLD).
      slv_lat = 3; i_ce = 1'b1; i_addr = 32'h0000_0100; stall_i = 1'b1;
      half(); next();
      flush_i = 1'b1;
      half(); chk("D_cyc_busy", wb_cyc_o, 1'b1); next();
      flush_i = 1'b0;
      half(); next();
      half(); next();
      half(); chk("D_ack", wb_ack_i, 1'b1); chk("D_istall_ack", i_stallreq_o, 1'b0); next();
      flush_i = 1'b1;
      half(); chk("D_no_hold", i_stallreq_o, 1'b1); chk("D_cyc_idle", wb_cyc_o, 1'b0); next();
      half(); chk("D_no_launch", wb_cyc_o, 1'b0);
      clear_inputs(); next();

      // Reset during a bus cycle.
      slv_lat = 5; d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0210; d_sel = 4'hF; d_wdata = 32'h1111_1111;
      half(); next();
      half(); chk("E_cyc_busy", wb_cyc_o, 1'b1); next();
      rst = 1'b0; d_ce = 1'b0; d_we = 1'b0;
      half(); chk("E_cyc_before_edge", wb_cyc_o, 1'b1); next();
      half();
      chk("E_cyc", wb_cyc_o, 1'b0); chk("E_stb", wb_stb_o, 1'b0); chk("E_we", wb_we_o, 1'b0);
      chk("E_adr", wb_adr_o, 32'h0); chk("E_sel", wb_sel_o, 4'h0); chk("E_dat", wb_dat_o, 32'h0);
      chk("E_istall", i_stallreq_o, 1'b0); chk("E_dstall", d_stallreq_o, 1'b0);
      chk("E_ddata", d_data_o, 32'h0);
      rst = 1'b1; clear_inputs(); next();

      // Randomized alternating I/D traffic against the reference memory.
      for (int t = 0; t < 20; t++) begin
         r_d     = (t % 2) == 1;
         slv_lat = r_d ? 5 : int'($urandom_range(0, 5));
         r_we    = r_d ? 1'($urandom_range(0, 1)) : 1'b0;
         r_addr  = 32'h0000_0200 + ($urandom_range(0, 7) << 2);
         r_sel   = r_we ? 4'($urandom_range(1, 15)) : 4'hF;
         r_data  = $urandom;
         r_stl   = 1'($urandom_range(0, 1));
         r_exp   = ref_read(int'(r_addr[9:2]));
         if (r_d) begin
            d_ce = 1'b1; d_we = r_we; d_addr = r_addr; d_sel = r_sel; d_wdata = r_data;
         end else begin
            i_ce = 1'b1; i_addr = r_addr;
         end
         stall_i = r_stl;
         waited = 0; done = 1'b0;
         while (!done && waited < 30) begin
            half();
            stl_now = r_d ? d_stallreq_o : i_stallreq_o;
            if (!stl_now) done = 1'b1;
            else begin next(); waited++; end
         end
         if (!done) begin
            checks++; errors++;
            $display("FAIL rand_timeout: txn %0d still stalled after 30 cycles, expected completion", t);
         end else begin
            chk($sformatf("rand%0d_latency", t), waited, slv_lat + 1);
            got = r_d ? d_data_o : i_data_o;
            if (!r_we) chk($sformatf("rand%0d_rdata", t), got, r_exp);
            else ref_write(int'(r_addr[9:2]), r_data, r_sel);
            next();
            if (r_stl) begin
               half();
               stl_now = r_d ? d_stallreq_o : i_stallreq_o;
               chk($sformatf("rand%0d_hold_stall", t), stl_now, 1'b0);
               got = r_d ? d_data_o : i_data_o;
               if (!r_we) chk($sformatf("rand%0d_hold_data", t), got, r_exp);
               stall_i = 1'b0; d_ce = 1'b0; i_ce = 1'b0;
               next();
            end
         end
         clear_inputs();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
